// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin writeback arbiter for the r0-r14 write port, with
//               r15 writes diverted to the PC. Optional pending-write
//               scoreboard is enabled by defining RFARB_SCOREBOARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_addr,
  input  logic [32*NREQ-1:0]   req_data,
  output logic                 we3,
  output logic [3:0]           wa3,
  output logic [31:0]          wd3,
  output logic                 pc_we,
  output logic [31:0]          pc_wd,
  input  logic                 rsv_valid,
  input  logic [3:0]           rsv_addr,
  output logic                 rsv_ready,
  output logic [14:0]          busy,
  output logic                 sb_err
);

  localparam int C_PW = (NREQ > 2) ? 2 : 1;

  logic [C_PW-1:0] r_ptr;
  logic [C_PW-1:0] w_win;
  logic [C_PW-1:0] w_ptr_nxt;
  logic            w_any;
  logic            w_xfer;
  logic [NREQ-1:0] w_grant;
  logic [3:0]      w_addr;
  logic [31:0]     w_data;
  int              w_dist;
  int              w_best;

  // Winner is the valid requester with the smallest upward distance from the pointer.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_best = NREQ;
    w_dist = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_dist = (k >= int'(r_ptr)) ? (k - int'(r_ptr)) : (k + NREQ - int'(r_ptr));
      if (req_valid[k] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_win  = C_PW'(k);
        w_any  = 1'b1;
      end
    end
  end

  always_comb begin
    w_grant = '0;
    w_addr  = '0;
    w_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_grant[k] = w_any && !hold && rst_n && (w_win == C_PW'(k));
      if (w_win == C_PW'(k)) begin
        w_addr = req_addr[4*k +: 4];
        w_data = req_data[32*k +: 32];
      end
    end
  end

  assign req_ready = w_grant;
  assign w_xfer    = |(req_valid & w_grant);
  assign w_ptr_nxt = (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      we3   <= 1'b0;
      wa3   <= '0;
      wd3   <= '0;
      pc_we <= 1'b0;
      pc_wd <= '0;
    end else begin
      we3   <= 1'b0;
      pc_we <= 1'b0;
      if (w_xfer) begin
        r_ptr <= w_ptr_nxt;
        if (w_addr == 4'hF) begin
          pc_we <= 1'b1;
          pc_wd <= w_data;
        end else begin
          we3 <= 1'b1;
          wa3 <= w_addr;
          wd3 <= w_data;
        end
      end
    end
  end

`ifdef RFARB_SCOREBOARD_EN
  logic [15:0] w_full;
  logic [14:0] w_underflow;
  logic        r_err;

  // Bit 15 stays clear so PC reservations are always accepted.
  assign w_full[15] = 1'b0;
  assign rsv_ready  = !w_full[rsv_addr];

  for (genvar r = 0; r < 15; r++) begin : g_cnt
    logic [1:0] r_cnt;
    logic       w_inc;
    logic       w_dec;

    assign w_inc = rsv_valid && rsv_ready && (rsv_addr == 4'(r));
    assign w_dec = we3 && (wa3 == 4'(r));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_inc && !w_dec) begin
        r_cnt <= r_cnt + 2'd1;
      end else if (w_dec && !w_inc && (r_cnt != 2'd0)) begin
        r_cnt <= r_cnt - 2'd1;
      end
    end

    assign w_full[r]      = (r_cnt == 2'd3);
    assign busy[r]        = (r_cnt != 2'd0);
    assign w_underflow[r] = w_dec && (r_cnt == 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (|w_underflow) begin
      r_err <= 1'b1;
    end
  end

  assign sb_err = r_err;
`else
  logic w_unused_rsv;

  assign w_unused_rsv = ^{rsv_valid, rsv_addr};
  assign rsv_ready    = 1'b1;
  assign busy         = '0;
  assign sb_err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed plus randomized bench for regfile_wb_arbiter against
//               a behavioural model of the arbitration and scoreboard rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int NREQ = 2;
`ifdef RFARB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                hold;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [4*NREQ-1:0]   req_addr;
  logic [32*NREQ-1:0]  req_data;
  logic                we3;
  logic [3:0]          wa3;
  logic [31:0]         wd3;
  logic                pc_we;
  logic [31:0]         pc_wd;
  logic                rsv_valid;
  logic [3:0]          rsv_addr;
  logic                rsv_ready;
  logic [14:0]         busy;
  logic                sb_err;

  regfile_wb_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .pc_we(pc_we), .pc_wd(pc_wd),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .busy(busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Requester-side state: a pending write stays presented until granted.
  bit          pend [NREQ];
  logic [3:0]  paddr[NREQ];
  logic [31:0] pdata[NREQ];
  bit          t_hold;
  bit          t_rv;
  logic [3:0]  t_ra;

  // Reference model state.
  int          m_ptr;
  bit          m_we, m_pcwe, m_err;
  logic [3:0]  m_wa;
  logic [31:0] m_wd, m_pcwd;
  int          m_cnt[15];
  int          last_grant;
  logic        obs_rsv;
  int          saved_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_we = 0; m_pcwe = 0; m_err = 0;
    m_wa = '0; m_wd = '0; m_pcwd = '0;
    last_grant = -1;
    for (int r = 0; r < 15; r++) m_cnt[r] = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
  endtask

  function automatic logic [14:0] exp_busy();
    logic [14:0] b;
    b = '0;
    for (int r = 0; r < 15; r++) b[r] = SB && (m_cnt[r] != 0);
    return b;
  endfunction

  task automatic chk_outputs(input string tag);
    chk($sformatf("%s.we3", tag), we3, m_we);
    chk($sformatf("%s.wa3", tag), wa3, m_wa);
    chk($sformatf("%s.wd3", tag), wd3, m_wd);
    chk($sformatf("%s.pc_we", tag), pc_we, m_pcwe);
    chk($sformatf("%s.pc_wd", tag), pc_wd, m_pcwd);
    chk($sformatf("%s.busy", tag), busy, exp_busy());
    chk($sformatf("%s.sb_err", tag), sb_err, SB && m_err);
  endtask

  // One clock: present inputs, check grant, clock, advance the model, check outputs.
  task automatic do_cycle(input string tag);
    int w;
    int idx;
    int dec_r;
    int inc_r;
    int d;
    bit exp_rsv;
    logic [NREQ-1:0] exp_rdy;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]        = pend[i];
      req_addr[4*i +: 4]  = paddr[i];
      req_data[32*i +: 32] = pdata[i];
    end
    hold = t_hold; rsv_valid = t_rv; rsv_addr = t_ra;
    #1;
    w = -1;
    if (!t_hold) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (w < 0 && pend[idx]) w = idx;
      end
    end
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    exp_rsv = (t_ra == 4'hF) ? 1'b1 : (m_cnt[t_ra] != 3);
    obs_rsv = rsv_ready;
    chk($sformatf("%s.req_ready", tag), req_ready, exp_rdy);
    chk($sformatf("%s.rsv_ready", tag), rsv_ready, SB ? exp_rsv : 1'b1);
    @(posedge clk); #1;
    dec_r = m_we ? int'(m_wa) : -1;
    inc_r = (t_rv && exp_rsv && t_ra != 4'hF) ? int'(t_ra) : -1;
    for (int r = 0; r < 15; r++) begin
      d = (r == inc_r ? 1 : 0) - (r == dec_r ? 1 : 0);
      if (r == dec_r && m_cnt[r] == 0) m_err = 1;
      if (m_cnt[r] + d >= 0) m_cnt[r] = m_cnt[r] + d;
    end
    m_we = 0; m_pcwe = 0;
    last_grant = w;
    if (w >= 0) begin
      if (paddr[w] == 4'hF) begin
        m_pcwe = 1; m_pcwd = pdata[w];
      end else begin
        m_we = 1; m_wa = paddr[w]; m_wd = pdata[w];
      end
      m_ptr = (w + 1) % NREQ;
      pend[w] = 0;
    end
    chk_outputs(tag);
  endtask

  task automatic arm(input int i, input logic [3:0] a, input logic [31:0] dt);
    pend[i] = 1; paddr[i] = a; pdata[i] = dt;
  endtask

  initial begin
    rst_n = 1'b0; hold = 0; rsv_valid = 0; rsv_addr = '0;
    req_valid = '1; req_addr = '0; req_data = '0;
    t_hold = 0; t_rv = 0; t_ra = '0;
    model_reset();
    saved_ptr = 0;

    // Reset state with requesters already valid.
    @(posedge clk); #1;
    chk("rst.req_ready", req_ready, '0);
    chk_outputs("rst");
    rst_n = 1'b1;

    // Reset release: both valid, addr 3/5.
    arm(0, 4'd3, 32'hA);
    arm(1, 4'd5, 32'hB);
    do_cycle("rr0");
    chk("rr0.wa3_abs", wa3, 32'd3);
    chk("rr0.wd3_abs", wd3, 32'hA);
    do_cycle("rr1");
    chk("rr1.grant_abs", last_grant, 1);
    chk("rr1.wa3_abs", wa3, 32'd5);
    chk("rr1.wd3_abs", wd3, 32'hB);

    // Fairness: requester 0 always valid, requester 1 re-armed for 4 cycles.
    for (int c = 0; c < 4; c++) begin
      if (!pend[0]) arm(0, 4'(c + 1), $urandom);
      if (!pend[1]) arm(1, 4'(c + 8), $urandom);
      do_cycle("fair");
      chk("fair.order", last_grant, c % 2);
    end
    for (int c = 0; c < 4; c++) if (pend[0] || pend[1]) do_cycle("drain");

    // PC write via requester 1.
    arm(1, 4'hF, 32'h0000_0100);
    do_cycle("pc");
    chk("pc.pc_we_abs", pc_we, 1);
    chk("pc.pc_wd_abs", pc_wd, 32'h100);
    chk("pc.we3_abs", we3, 0);

    // hold for 3 cycles with both requesters valid.
    arm(0, 4'd2, $urandom);
    arm(1, 4'd4, $urandom);
    do_cycle("prehold");
    for (int i = 0; i < NREQ; i++) if (!pend[i]) arm(i, 4'(i + 10), $urandom);
    saved_ptr = m_ptr;
    t_hold = 1;
    for (int c = 0; c < 3; c++) do_cycle("hold");
    chk("hold.we3_abs", we3, 0);
    t_hold = 0;
    do_cycle("release");
    chk("release.resume", last_grant, saved_ptr);
    do_cycle("release2");

    // Asynchronous reset while a write is being emitted.
    arm(0, 4'd6, $urandom);
    t_rv = 1; t_ra = 4'd9;
    do_cycle("prerst");
    t_rv = 0;
    chk("prerst.we3_abs", we3, 1);
    rst_n = 1'b0;
    #1;
    req_valid = '1;
    model_reset();
    #1;
    chk("arst.we3", we3, 0);
    chk("arst.pc_we", pc_we, 0);
    chk("arst.busy", busy, '0);
    chk("arst.req_ready", req_ready, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Scoreboard: three reservations of r7, then a blocked fourth.
    t_rv = 1; t_ra = 4'd7;
    for (int c = 0; c < 3; c++) do_cycle("rsv");
    chk("sb.busy7_set", busy[7], SB);
    do_cycle("rsv4");
    chk("sb.full", obs_rsv, SB ? 1'b0 : 1'b1);
    t_rv = 0;
    for (int c = 0; c < 3; c++) begin
      arm(0, 4'd7, $urandom);
      do_cycle("wr7");
    end
    do_cycle("wr7idle");
    chk("sb.busy7_clr", busy[7], 0);
    chk("sb.err_clean", sb_err, 0);
    arm(0, 4'd7, $urandom);
    do_cycle("wr7x");
    do_cycle("wr7xidle");
    chk("sb.err_set", sb_err, SB);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && ($urandom_range(0, 2) != 0)) arm(i, 4'($urandom_range(0, 15)), $urandom);
      t_hold = ($urandom_range(0, 5) == 0);
      t_rv   = ($urandom_range(0, 1) == 1);
      t_ra   = 4'($urandom_range(0, 15));
      do_cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
